// File: rtl/iob_uart_fifo_pkg.sv
// Shared encodings for the buffered UART core: parity modes, engine states, limits.
package iob_uart_fifo_pkg;

    localparam int MIN_DIV   = 4;
    localparam int MIN_DBITS = 5;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'd0,
        PAR_EVEN     = 2'd1,
        PAR_ODD      = 2'd2,
        PAR_NONE_ALT = 2'd3
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic par_on(input logic [1:0] p);
        return (p == PAR_EVEN) || (p == PAR_ODD);
    endfunction

endpackage

// File: rtl/iob_uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; head word reads as zero when empty.
module iob_uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cke_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [ADDR_W:0]   level_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LVL_ONE = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              do_push, do_pop;

    // Level never exceeds DEPTH, so its MSB alone marks full.
    assign full_o  = level_q[ADDR_W];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign data_o  = empty_o ? '0 : mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
        if (do_push && !do_pop)      level_d = level_q + LVL_ONE;
        else if (!do_push && do_pop) level_d = level_q - LVL_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (cke_i) begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i && do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/iob_uart_fifo_core.sv
// UART datapath: FIFO-buffered TX/RX engines with runtime frame format, sticky errors and RTS/CTS.
module iob_uart_fifo_core
    import iob_uart_fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DIV_W       = 16,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cke_i,
    input  logic [DIV_W-1:0]       div_i,
    input  logic [3:0]             dbits_i,
    input  logic [1:0]             parity_i,
    input  logic                   stop2_i,
    input  logic                   txen_i,
    input  logic                   rxen_i,
    input  logic [DATA_W-1:0]      tx_data_i,
    input  logic                   tx_valid_i,
    output logic                   tx_ready_o,
    output logic [DATA_W-1:0]      rx_data_o,
    output logic                   rx_valid_o,
    input  logic                   rx_ready_i,
    output logic [FIFO_ADDR_W:0]   tx_level_o,
    output logic [FIFO_ADDR_W:0]   rx_level_o,
    output logic [2:0]             err_o,
    input  logic                   err_clr_i,
    output logic                   rs232_txd_o,
    input  logic                   rs232_rxd_i,
    output logic                   rs232_rts_o,
    input  logic                   rs232_cts_i
);

    localparam logic [DIV_W-1:0]     DIV_ONE = DIV_W'(1);
    localparam logic [FIFO_ADDR_W:0] LVL_ONE = (FIFO_ADDR_W+1)'(1);
    localparam logic [FIFO_ADDR_W:0] RTS_MAX = (FIFO_ADDR_W+1)'((1 << FIFO_ADDR_W) - 2);

    function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
    endfunction

    function automatic logic [3:0] sat_dbits(input logic [3:0] d);
        if (d < 4'(MIN_DBITS)) return 4'(MIN_DBITS);
        if (d > 4'(DATA_W))    return 4'(DATA_W);
        return d;
    endfunction

    function automatic logic [DATA_W-1:0] dmask(input logic [3:0] n);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_W; i++) if (4'(i) < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic par_bit(input logic [DATA_W-1:0] d, input logic [1:0] p);
        return (p == PAR_ODD) ? ~(^d) : (^d);
    endfunction

    logic [DIV_W-1:0]  div_sat;
    logic [3:0]        dbits_sat;
    assign div_sat   = sat_div(div_i);
    assign dbits_sat = sat_dbits(dbits_i);

    logic [DATA_W-1:0] tx_fifo_data;
    logic              tx_full, tx_empty, tx_pop;
    logic              rx_full, rx_empty, rx_push;

    iob_uart_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(FIFO_ADDR_W)) u_tx_fifo (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cke_i(cke_i),
        .push_i(tx_valid_i), .data_i(tx_data_i), .pop_i(tx_pop),
        .data_o(tx_fifo_data), .full_o(tx_full), .empty_o(tx_empty), .level_o(tx_level_o)
    );

    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;

    iob_uart_sync_fifo #(.DATA_W(DATA_W), .ADDR_W(FIFO_ADDR_W)) u_rx_fifo (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cke_i(cke_i),
        .push_i(rx_push), .data_i(rx_sh_q), .pop_i(rx_ready_i),
        .data_o(rx_data_o), .full_o(rx_full), .empty_o(rx_empty), .level_o(rx_level_o)
    );

    assign tx_ready_o = ~tx_full;
    assign rx_valid_o = ~rx_empty;

    tx_state_e         tx_st_q, tx_st_d;
    logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [3:0]        tx_idx_q, tx_idx_d, tx_nb_q, tx_nb_d;
    logic [1:0]        tx_par_q, tx_par_d;
    logic              tx_stop2_q, tx_stop2_d, tx_pbit_q, tx_pbit_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              txd_q, txd_d;

    // Frame format is captured when a word is popped; later config changes wait for the next frame.
    always_comb begin
        tx_st_d    = tx_st_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_idx_d   = tx_idx_q;
        tx_nb_d    = tx_nb_q;
        tx_par_d   = tx_par_q;
        tx_stop2_d = tx_stop2_q;
        tx_pbit_d  = tx_pbit_q;
        tx_sh_d    = tx_sh_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        if (tx_st_q == TX_IDLE) begin
            txd_d = 1'b1;
            if (txen_i && rs232_cts_i && !tx_empty) begin
                tx_pop     = 1'b1;
                tx_st_d    = TX_START;
                tx_div_d   = div_sat;
                tx_cnt_d   = div_sat - DIV_ONE;
                tx_nb_d    = dbits_sat;
                tx_par_d   = parity_i;
                tx_stop2_d = stop2_i;
                tx_sh_d    = tx_fifo_data & dmask(dbits_sat);
                tx_pbit_d  = par_bit(tx_fifo_data & dmask(dbits_sat), parity_i);
                tx_idx_d   = '0;
                txd_d      = 1'b0;
            end
        end else if (tx_cnt_q != '0) begin
            tx_cnt_d = tx_cnt_q - DIV_ONE;
        end else begin
            tx_cnt_d = tx_div_q - DIV_ONE;
            case (tx_st_q)
                TX_START: begin
                    tx_st_d = TX_DATA;
                    txd_d   = tx_sh_q[0];
                end
                TX_DATA: begin
                    if (tx_idx_q == tx_nb_q - 4'd1) begin
                        if (par_on(tx_par_q)) begin
                            tx_st_d = TX_PARITY;
                            txd_d   = tx_pbit_q;
                        end else begin
                            tx_st_d = TX_STOP1;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        tx_idx_d = tx_idx_q + 4'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                        txd_d    = tx_sh_q[1];
                    end
                end
                TX_PARITY: begin
                    tx_st_d = TX_STOP1;
                    txd_d   = 1'b1;
                end
                TX_STOP1: begin
                    tx_st_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
                    txd_d   = 1'b1;
                end
                default: begin
                    tx_st_d = TX_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_idx_q <= '0;
            txd_q    <= 1'b1;
        end else if (cke_i) begin
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_idx_q <= tx_idx_d;
            txd_q    <= txd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            tx_div_q   <= tx_div_d;
            tx_nb_q    <= tx_nb_d;
            tx_par_q   <= tx_par_d;
            tx_stop2_q <= tx_stop2_d;
            tx_pbit_q  <= tx_pbit_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    assign rs232_txd_o = txd_q;

    rx_state_e         rx_st_q, rx_st_d;
    logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [3:0]        rx_idx_q, rx_idx_d, rx_nb_q, rx_nb_d;
    logic [1:0]        rx_par_q, rx_par_d;
    logic              rx_perr_q, rx_perr_d;
    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    logic              set_frame, set_par;

    // rx_s3_q is the previous synchronised sample, used only to spot the start-bit falling edge.
    always_comb begin
        rx_st_d   = rx_st_q;
        rx_cnt_d  = rx_cnt_q;
        rx_div_d  = rx_div_q;
        rx_idx_d  = rx_idx_q;
        rx_nb_d   = rx_nb_q;
        rx_par_d  = rx_par_q;
        rx_perr_d = rx_perr_q;
        rx_sh_d   = rx_sh_q;
        rx_push   = 1'b0;
        set_frame = 1'b0;
        set_par   = 1'b0;
        if (!rxen_i) begin
            rx_st_d = RX_IDLE;
        end else if (rx_st_q == RX_IDLE) begin
            if (rx_s3_q && !rx_s2_q) begin
                rx_st_d   = RX_START;
                rx_div_d  = div_sat;
                rx_cnt_d  = (div_sat >> 1) - DIV_ONE;
                rx_nb_d   = dbits_sat;
                rx_par_d  = parity_i;
                rx_perr_d = 1'b0;
                rx_sh_d   = '0;
                rx_idx_d  = '0;
            end
        end else if (rx_cnt_q != '0) begin
            rx_cnt_d = rx_cnt_q - DIV_ONE;
        end else begin
            rx_cnt_d = rx_div_q - DIV_ONE;
            case (rx_st_q)
                RX_START: rx_st_d = rx_s2_q ? RX_IDLE : RX_DATA;
                RX_DATA: begin
                    rx_sh_d = rx_sh_q | (DATA_W'(rx_s2_q) << rx_idx_q);
                    if (rx_idx_q == rx_nb_q - 4'd1)
                        rx_st_d = par_on(rx_par_q) ? RX_PARITY : RX_STOP;
                    else
                        rx_idx_d = rx_idx_q + 4'd1;
                end
                RX_PARITY: begin
                    rx_perr_d = (rx_s2_q != par_bit(rx_sh_q, rx_par_q));
                    rx_st_d   = RX_STOP;
                end
                default: begin
                    rx_push   = 1'b1;
                    set_frame = ~rx_s2_q;
                    set_par   = rx_perr_q;
                    rx_st_d   = RX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_idx_q  <= '0;
            rx_perr_q <= 1'b0;
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_s3_q   <= 1'b1;
        end else if (cke_i) begin
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_idx_q  <= rx_idx_d;
            rx_perr_q <= rx_perr_d;
            rx_s1_q   <= rs232_rxd_i;
            rx_s2_q   <= rx_s1_q;
            rx_s3_q   <= rx_s2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            rx_div_q <= rx_div_d;
            rx_nb_q  <= rx_nb_d;
            rx_par_q <= rx_par_d;
            rx_sh_q  <= rx_sh_d;
        end
    end

    logic [2:0]             err_q, err_d;
    logic                   rx_push_ok, rx_pop_ok, rts_q, rts_d;
    logic [FIFO_ADDR_W:0]   rx_lvl_nxt;

    assign rx_push_ok = rx_push & ~rx_full;
    assign rx_pop_ok  = rx_ready_i & ~rx_empty;

    // RTS tracks the level the RX FIFO will hold after this edge, so it drops together with the level.
    always_comb begin
        rx_lvl_nxt = rx_level_o;
        if (rx_push_ok && !rx_pop_ok)      rx_lvl_nxt = rx_level_o + LVL_ONE;
        else if (!rx_push_ok && rx_pop_ok) rx_lvl_nxt = rx_level_o - LVL_ONE;
        rts_d = rxen_i & (rx_lvl_nxt <= RTS_MAX);
        err_d = (err_clr_i ? 3'b000 : err_q) | {rx_push & rx_full, set_frame, set_par};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_q <= '0;
            rts_q <= 1'b0;
        end else if (cke_i) begin
            err_q <= err_d;
            rts_q <= rts_d;
        end
    end

    assign err_o       = err_q;
    assign rs232_rts_o = rts_q;

endmodule
